cordic_front_end: RTL and testbench
===================================

# cordic_front_end

Input stage for the 16-stage CORDIC rotation pipeline. Accepts angle requests with a tag and folds each angle into the pipeline's convergence range of [-pi/2, pi/2]. Drives the pipeline's initial X/Y/Z/negate inputs from registers. Carries a valid/tag shadow alongside the fixed-latency datapath, so downstream logic sees an `Out_valid` aligned with the pipeline's final outputs.

## Interface
Parameters:
- `STAGES`, 16, pipeline depth being shadowed.
- `TAG_W`, 4, width of the request tag.
- `X_INIT`, 16'sd9949, CORDIC gain-compensated initial X (0.60725 in Q1.14).
- `HALF_PI`, 16'sd12868, pi/2 in Q2.13 radians.
- `PI`, 16'sd25736, pi in Q2.13 radians.

Ports:
- `Clk` in 1: single clock; all logic is on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `In_valid` in 1: a request is present.
- `In_ready` out 1: the block accepts a request this cycle.
- `In_angle` in 16 signed: angle, Q2.13 radians, nominal range [-PI, PI].
- `In_tag` in TAG_W: opaque request tag.
- `Initial_x`, `Initial_y`, `Initial_z` out 16 signed: registered pipeline inputs.
- `Initial_cos_negate` out 1: registered fold flag to the pipeline.
- `Out_valid` out 1: high when the pipeline's final outputs correspond to an accepted request.
- `Out_tag` out TAG_W: tag of that request.
- `Inflight` out 5: number of requests accepted but not yet emitted (0..STAGES+1).
- `Idle` out 1: `Inflight == 0`.
- `Range_err` out 1: sticky out-of-range flag (see Configuration).

## Operation
- Accept condition: `In_valid && In_ready`. `In_ready = !Reset`. There is no backpressure, because the pipeline never stalls.
- Fold is computed on the accept edge, on the signed 16-bit `In_angle`:
  - `In_angle > HALF_PI`: `Initial_z <= In_angle - PI`, negate <= 1.
  - `In_angle < -HALF_PI`: `Initial_z <= In_angle + PI`, negate <= 1.
  - Otherwise: `Initial_z <= In_angle`, negate <= 0.
  - Exactly ±HALF_PI does not fold.
- Fold arithmetic is 16-bit signed and cannot overflow for any 16-bit input: the results lie in [-7032, 7031] beyond the fold point.
- On accept: `Initial_x <= X_INIT`, `Initial_y <= 0`.
- Non-accept cycle: `Initial_x`, `Initial_y`, `Initial_z` and negate load 0 (bubble). Bubbles have no observable effect because the valid shadow marks them invalid.
- Valid/tag shadow: a shift register of depth `STAGES+1`.
  - Entry 0 loads `{accept, In_tag}` every cycle.
  - Each entry shifts by one per cycle.
  - The last entry drives `Out_valid` and `Out_tag`.
  - `Out_tag` holds the shifted tag even when `Out_valid` = 0; downstream logic ignores it in that case.
- `Inflight` counter:
  - +1 on accept, -1 on `Out_valid`.
  - Both in the same cycle: unchanged.
  - Cannot exceed `STAGES+1`.

## Timing
- Latency: a request accepted at edge E0 produces `Out_valid` = 1 after edge E(STAGES+1), which is 17 cycles by default. That is the same cycle the pipeline's final X/Y/negate reflect it.
- Throughput: one request per cycle, sustained indefinitely.
- Reset values (the cycle after any edge with `Reset` = 1):
  - `Initial_*` = 0, negate = 0.
  - All shadow entries = 0, so `Out_valid` = 0 and `Out_tag` = 0.
  - `Inflight` = 0, `Idle` = 1, `Range_err` = 0.
  - `In_ready` = 0 while `Reset` is high.
- Reset mid-operation:
  - All in-flight requests are discarded and no `Out_valid` is emitted for them.
  - The pipeline resets in the same cycle, so the first post-reset accept is clean.
- `Idle` is combinational from `Inflight`.

## Configuration
- Macro `CORDIC_RANGE_CHECK_EN`.
- Defined:
  - An accepted `In_angle` > PI is clamped to PI before folding; one < -PI is clamped to -PI.
  - `Range_err` is set on the accept edge of any clamped request and stays set until `Reset`.
- Undefined:
  - No clamp; angles outside [-PI, PI] fold with the rules above, and the result is unspecified but non-overflowing.
  - `Range_err` is tied 0.

## Test plan
- Reset, then accept `In_angle` = 0, tag 3:
  - Next cycle: `Initial_x` = 9949, `Initial_y` = 0, `Initial_z` = 0, negate = 0.
  - `Out_valid` = 1 with `Out_tag` = 3 exactly 17 cycles after the accept edge.
  - `Inflight` returns to 0.
- Fold cases:
  - `In_angle` = 20000 -> `Initial_z` = -5736, negate = 1.
  - `In_angle` = -20000 -> `Initial_z` = 5736, negate = 1.
  - `In_angle` = 12868 -> z = 12868, negate = 0.
  - `In_angle` = 12869 -> z = -12867, negate = 1.
- Back-to-back: 40 consecutive accepts, tags 0..15 repeating. `Out_valid` stays high for 40 consecutive cycles, with tags in order, and `Inflight` peaks at 17.
- Pulse `Reset` for 1 cycle with 10 requests in flight. No `Out_valid` follows for 20 cycles; then one new accept emits after exactly 17 cycles.
- With `CORDIC_RANGE_CHECK_EN` defined, `In_angle` = 30000:
  - Clamped to 25736, so `Initial_z` = 0, negate = 1.
  - `Range_err` = 1 and held; cleared only by `Reset`.
- Without the macro, the same stimulus gives `Initial_z` = 4264, negate = 1, `Range_err` = 0.

Source files
------------

// File: rtl/cordic_front_end.sv
// Input stage for the CORDIC rotation pipeline: angle fold, initial X/Y/Z, valid/tag shadow.
// Optional angle clamp and sticky range error enabled by defining CORDIC_RANGE_CHECK_EN.
module cordic_front_end #(
    parameter int unsigned        STAGES  = 16,
    parameter int unsigned        TAG_W   = 4,
    parameter logic signed [15:0] X_INIT  = 16'sd9949,
    parameter logic signed [15:0] HALF_PI = 16'sd12868,
    parameter logic signed [15:0] PI      = 16'sd25736
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    In_valid,
    output logic                    In_ready,
    input  logic signed [15:0]      In_angle,
    input  logic [TAG_W-1:0]        In_tag,
    output logic signed [15:0]      Initial_x,
    output logic signed [15:0]      Initial_y,
    output logic signed [15:0]      Initial_z,
    output logic                    Initial_cos_negate,
    output logic                    Out_valid,
    output logic [TAG_W-1:0]        Out_tag,
    output logic [4:0]              Inflight,
    output logic                    Idle,
    output logic                    Range_err
);

    localparam int unsigned DEPTH = STAGES + 1;

    logic                         accept_c;
    logic signed [15:0]           angle_c;
    logic                         clamp_hit_c;
    logic signed [15:0]           fold_z_c;
    logic                         fold_neg_c;
    logic [DEPTH-1:0]             shadow_valid;
    logic [DEPTH-1:0][TAG_W-1:0]  shadow_tag;

    assign In_ready = !Reset;
    assign accept_c = In_valid && In_ready;
    assign Idle     = (Inflight == 5'd0);

`ifdef CORDIC_RANGE_CHECK_EN
    // Saturate out-of-range requests to +/-PI before folding
    always_comb begin
        angle_c     = In_angle;
        clamp_hit_c = 1'b0;
        if (In_angle > PI) begin
            angle_c     = PI;
            clamp_hit_c = 1'b1;
        end else if (In_angle < -PI) begin
            angle_c     = -PI;
            clamp_hit_c = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Range_err <= 1'b0;
        end else if (accept_c && clamp_hit_c) begin
            Range_err <= 1'b1;
        end
    end
`else
    assign angle_c     = In_angle;
    assign clamp_hit_c = 1'b0;
    assign Range_err   = 1'b0;
`endif

    // Fold into [-pi/2, pi/2]; exactly +/-pi/2 stays unfolded
    always_comb begin
        fold_z_c   = angle_c;
        fold_neg_c = 1'b0;
        if (angle_c > HALF_PI) begin
            fold_z_c   = angle_c - PI;
            fold_neg_c = 1'b1;
        end else if (angle_c < -HALF_PI) begin
            fold_z_c   = angle_c + PI;
            fold_neg_c = 1'b1;
        end
    end

    // Pipeline initial values; non-accept cycles inject a zero bubble
    always_ff @(posedge Clk) begin
        if (Reset || !accept_c) begin
            Initial_x          <= 16'sd0;
            Initial_y          <= 16'sd0;
            Initial_z          <= 16'sd0;
            Initial_cos_negate <= 1'b0;
        end else begin
            Initial_x          <= X_INIT;
            Initial_y          <= 16'sd0;
            Initial_z          <= fold_z_c;
            Initial_cos_negate <= fold_neg_c;
        end
    end

    // Valid/tag shadow, plus the output register aligned with the pipeline's last stage
    always_ff @(posedge Clk) begin
        if (Reset) begin
            shadow_valid <= '0;
            shadow_tag   <= '0;
            Out_valid    <= 1'b0;
            Out_tag      <= '0;
        end else begin
            shadow_valid <= {shadow_valid[DEPTH-2:0], accept_c};
            shadow_tag   <= {shadow_tag[DEPTH-2:0], In_tag};
            Out_valid    <= shadow_valid[DEPTH-1];
            Out_tag      <= shadow_tag[DEPTH-1];
        end
    end

    // A request leaves the count on the edge that presents it on Out_valid
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Inflight <= 5'd0;
        end else begin
            Inflight <= Inflight + 5'(accept_c) - 5'(shadow_valid[DEPTH-1]);
        end
    end

endmodule

// File: tb/tb_cordic_front_end.sv
// Randomized self-checking bench for cordic_front_end with a queue-based reference model.
// Honors CORDIC_RANGE_CHECK_EN in the same way as the design build.
module tb_cordic_front_end;

    localparam int LAT = 17;

    logic               Clk;
    logic               Reset;
    logic               In_valid;
    logic               In_ready;
    logic signed [15:0] In_angle;
    logic [3:0]         In_tag;
    logic signed [15:0] Initial_x;
    logic signed [15:0] Initial_y;
    logic signed [15:0] Initial_z;
    logic               Initial_cos_negate;
    logic               Out_valid;
    logic [3:0]         Out_tag;
    logic [4:0]         Inflight;
    logic               Idle;
    logic               Range_err;

    cordic_front_end dut (
        .Clk                (Clk),
        .Reset              (Reset),
        .In_valid           (In_valid),
        .In_ready           (In_ready),
        .In_angle           (In_angle),
        .In_tag             (In_tag),
        .Initial_x          (Initial_x),
        .Initial_y          (Initial_y),
        .Initial_z          (Initial_z),
        .Initial_cos_negate (Initial_cos_negate),
        .Out_valid          (Out_valid),
        .Out_tag            (Out_tag),
        .Inflight           (Inflight),
        .Idle               (Idle),
        .Range_err          (Range_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int emit_edge;
        int tag;
    } pend_t;

    pend_t pending[$];
    int    edge_cnt;
    int    n_checks;
    int    n_errors;
    bit    exp_rerr;
    int    run_len;
    int    max_run;
    int    peak_inflight;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_cnt);
        end
    endtask

    // One clock: drive inputs, advance, update model, compare every output
    task automatic step(input bit rst, input bit v, input int angle, input int tag);
        int  a;
        int  ez;
        int  ex;
        bit  en;
        bit  ev;
        int  et;
        bit  acc;
        Reset    = rst;
        In_valid = v;
        In_angle = 16'(angle);
        In_tag   = 4'(tag);
        #1;
        chk("in_ready", int'(In_ready), rst ? 0 : 1);
        acc = !rst && v;
        a   = int'(In_angle);
        ex = 0; ez = 0; en = 0;
        if (acc) begin
`ifdef CORDIC_RANGE_CHECK_EN
            if (a > 25736) begin a = 25736; exp_rerr = 1; end
            else if (a < -25736) begin a = -25736; exp_rerr = 1; end
`endif
            ex = 9949;
            if (a > 12868) begin ez = a - 25736; en = 1; end
            else if (a < -12868) begin ez = a + 25736; en = 1; end
            else ez = a;
        end
        @(posedge Clk);
        #1;
        edge_cnt++;
        ev = 0; et = 0;
        if (rst) begin
            pending.delete();
            exp_rerr = 0;
        end else begin
            if (pending.size() > 0 && pending[0].emit_edge == edge_cnt) begin
                ev = 1;
                et = pending[0].tag;
                void'(pending.pop_front());
            end
            if (acc) pending.push_back('{edge_cnt + LAT, tag & 15});
        end
        chk("initial_x", int'(Initial_x), ex);
        chk("initial_y", int'(Initial_y), 0);
        chk("initial_z", int'(Initial_z), ez);
        chk("negate", int'(Initial_cos_negate), int'(en));
        chk("out_valid", int'(Out_valid), int'(ev));
        if (ev || rst) chk("out_tag", int'(Out_tag), et);
        chk("inflight", int'(Inflight), pending.size());
        chk("idle", int'(Idle), pending.size() == 0 ? 1 : 0);
        chk("range_err", int'(Range_err), int'(exp_rerr));
        if (Out_valid) run_len++; else run_len = 0;
        if (run_len > max_run) max_run = run_len;
        if (int'(Inflight) > peak_inflight) peak_inflight = int'(Inflight);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dir_angles[$];
        n_checks = 0; n_errors = 0; edge_cnt = 0;
        exp_rerr = 0; run_len = 0; max_run = 0; peak_inflight = 0;
        Reset = 1; In_valid = 0; In_angle = '0; In_tag = '0;

        step(1, 0, 0, 0);
        step(1, 1, 1000, 5);

        // Single request with tag 3 through the full latency
        step(0, 1, 0, 3);
        idle_cycles(20);

        // Fold boundaries and out-of-range values
        dir_angles = '{20000, -20000, 12868, 12869, -12868, -12869,
                       25736, -25736, 32767, -32768, 30000};
        foreach (dir_angles[i]) step(0, 1, dir_angles[i], i);
        idle_cycles(5);
        step(1, 0, 0, 0);
        idle_cycles(20);

        // Back-to-back stream
        max_run = 0; peak_inflight = 0;
        for (int i = 0; i < 40; i++) step(0, 1, int'($urandom_range(0, 51472)) - 25736, i % 16);
        idle_cycles(20);
        chk("b2b_run", max_run, 40);
        chk("b2b_peak", peak_inflight, 17);

        // Reset with requests in flight
        for (int i = 0; i < 10; i++) step(0, 1, i * 100, i);
        step(1, 0, 0, 0);
        max_run = 0;
        idle_cycles(20);
        chk("post_reset_quiet", max_run, 0);
        step(0, 1, 500, 9);
        idle_cycles(20);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
                 int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 15)));
        end
        idle_cycles(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
